// File: rtl/sdram_cmd_tracker.sv
// sdram_cmd_tracker: decodes the internal SDRAM command bus, tracks per-bank state and
// tRCD/tRP/tRFC windows, publishes bank readiness and flags illegal commands.
// Optional SDRAM_TRACK_LOG_EN adds a saturating violation counter and first-violation code.
module sdram_cmd_tracker #(
    parameter int T_RCD = 2,
    parameter int T_RP  = 2,
    parameter int T_RFC = 7
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [3:0] command,
    input  logic [1:0] bank,
    output logic [3:0] bank_open,
    output logic [3:0] bank_ready,
    output logic [3:0] bank_idle,
    output logic       all_idle,
    output logic       violation,
`ifdef SDRAM_TRACK_LOG_EN
    output logic [7:0] viol_count,
    output logic [2:0] first_code,
`endif
    output logic [2:0] viol_code
);

    typedef enum logic [1:0] {IDLE, ACTIVATING, OPEN, PRECHARGING} state_t;

    localparam logic [3:0] CMD_NOP   = 4'd0;
    localparam logic [3:0] CMD_ACT   = 4'd1;
    localparam logic [3:0] CMD_READ  = 4'd2;
    localparam logic [3:0] CMD_WRITE = 4'd3;
    localparam logic [3:0] CMD_PALL  = 4'd4;
    localparam logic [3:0] CMD_PRE   = 4'd5;
    localparam logic [3:0] CMD_REF   = 4'd6;
    localparam logic [3:0] CMD_MRS   = 4'd7;

    state_t     st [4];
    logic [3:0] cnt [4];
    logic       refreshing;
    logic [4:0] rcnt;
    logic       any_act;
    logic [2:0] code;
    logic       viol;
    state_t     sel;

    // Status outputs are pure decodes of the state registers, so they follow the sampling edge
    always_comb begin
        any_act = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bank_open[i]  = st[i] == ACTIVATING || st[i] == OPEN;
            bank_ready[i] = st[i] == OPEN;
            bank_idle[i]  = st[i] == IDLE && !refreshing;
            any_act       = any_act | (st[i] == ACTIVATING);
        end
        all_idle = bank_idle == 4'hF;
    end

    // Legality check against the pre-transition state, first matching reason wins
    always_comb begin
        sel  = st[bank];
        code = (refreshing && command != CMD_NOP)                                  ? 3'd5 :
               command[3]                                                          ? 3'd6 :
               (command == CMD_ACT && sel != IDLE)                                 ? 3'd1 :
               ((command == CMD_READ || command == CMD_WRITE) && sel != OPEN)      ? 3'd2 :
               ((command == CMD_PRE && sel == ACTIVATING) ||
                (command == CMD_PALL && any_act))                                  ? 3'd3 :
               ((command == CMD_REF || command == CMD_MRS) && !all_idle)           ? 3'd4 :
                                                                                     3'd0;
        viol = code != 3'd0;
    end

    // Bank/refresh timers and state; an illegal command leaves everything but the timers alone
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < 4; i++) begin
                st[i]  <= IDLE;
                cnt[i] <= 4'd0;
            end
            refreshing <= 1'b0;
            rcnt       <= 5'd0;
            violation  <= 1'b0;
            viol_code  <= 3'd0;
        end else begin
            violation <= viol;
            viol_code <= code;
            for (int i = 0; i < 4; i++) begin
                if (cnt[i] != 4'd0)
                    cnt[i] <= cnt[i] - 4'd1;
                if (cnt[i] == 4'd1)
                    st[i] <= (st[i] == ACTIVATING) ? OPEN : IDLE;
                if (!viol && command == CMD_ACT && bank == 2'(i)) begin
                    st[i]  <= (T_RCD == 1) ? OPEN : ACTIVATING;
                    cnt[i] <= 4'(T_RCD - 1);
                end
                if (!viol && st[i] == OPEN &&
                    (command == CMD_PALL || (command == CMD_PRE && bank == 2'(i)))) begin
                    st[i]  <= (T_RP == 1) ? IDLE : PRECHARGING;
                    cnt[i] <= 4'(T_RP - 1);
                end
            end
            if (rcnt != 5'd0)
                rcnt <= rcnt - 5'd1;
            if (rcnt == 5'd1)
                refreshing <= 1'b0;
            if (!viol && command == CMD_REF) begin
                refreshing <= T_RFC != 1;
                rcnt       <= 5'(T_RFC - 1);
            end
        end
    end

`ifdef SDRAM_TRACK_LOG_EN
    // Saturating violation count; the code of the first pulse after reset is kept
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            viol_count <= 8'd0;
            first_code <= 3'd0;
        end else if (violation) begin
            if (viol_count == 8'd0)
                first_code <= viol_code;
            if (viol_count != 8'hFF)
                viol_count <= viol_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_cmd_tracker.sv
// tb_sdram_cmd_tracker: vector table, corner sequences and random commands checked
// against a timestamp-based model of bank and refresh windows.
module tb_sdram_cmd_tracker;

    localparam int T_RCD = 2;
    localparam int T_RP  = 2;
    localparam int T_RFC = 7;

    logic       clk;
    logic       n_rst;
    logic [3:0] command;
    logic [1:0] bank;
    logic [3:0] bank_open, bank_ready, bank_idle;
    logic       all_idle, violation;
    logic [2:0] viol_code;
`ifdef SDRAM_TRACK_LOG_EN
    logic [7:0] viol_count;
    logic [2:0] first_code;
`endif
    logic [16:0] got;

    int tests = 0;
    int fails = 0;

    sdram_cmd_tracker #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .command(command),
        .bank(bank),
        .bank_open(bank_open),
        .bank_ready(bank_ready),
        .bank_idle(bank_idle),
        .all_idle(all_idle),
        .violation(violation),
`ifdef SDRAM_TRACK_LOG_EN
        .viol_count(viol_count),
        .first_code(first_code),
`endif
        .viol_code(viol_code)
    );

    assign got = {bank_open, bank_ready, bank_idle, all_idle, violation, viol_code};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: a bank is described only by whether a row is open and when it was last
    // activated / precharged; refresh by when it started. States follow from elapsed time.
    logic mopen [4];
    int   act_t [4];
    int   pre_t [4];
    int   ref_t;
    int   now;

    // 0 idle, 1 activating, 2 open, 3 precharging
    function automatic int bst(int b, int t);
        if (mopen[b])
            return (t < act_t[b] + T_RCD) ? 1 : 2;
        return (t < pre_t[b] + T_RP) ? 3 : 0;
    endfunction

    function automatic logic refr(int t);
        return t < ref_t + T_RFC;
    endfunction

    function automatic logic m_all_idle(int t);
        logic a;
        a = !refr(t);
        for (int i = 0; i < 4; i++)
            if (bst(i, t) != 0) a = 1'b0;
        return a;
    endfunction

    function automatic logic [2:0] mcode(logic [3:0] c, int b);
        int   s;
        logic aa;
        s  = bst(b, now);
        aa = 1'b0;
        for (int i = 0; i < 4; i++)
            if (bst(i, now) == 1) aa = 1'b1;
        if (refr(now) && c != 0) return 3'd5;
        if (c >= 8) return 3'd6;
        if (c == 1 && s != 0) return 3'd1;
        if ((c == 2 || c == 3) && s != 2) return 3'd2;
        if ((c == 5 && s == 1) || (c == 4 && aa)) return 3'd3;
        if ((c == 6 || c == 7) && !m_all_idle(now)) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [16:0] mout(logic [2:0] code);
        logic [3:0] o, r, id;
        int s;
        for (int i = 0; i < 4; i++) begin
            s     = bst(i, now);
            o[i]  = s == 1 || s == 2;
            r[i]  = s == 2;
            id[i] = s == 0 && !refr(now);
        end
        return {o, r, id, id == 4'hF, code != 3'd0, code};
    endfunction

    logic [16:0] mexp;

    task automatic check(input string nm, input int idx, input logic [16:0] g, input logic [16:0] e);
        tests++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, g, e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mopen[i] = 1'b0;
            act_t[i] = -100;
            pre_t[i] = -100;
        end
        ref_t = -100;
        now   = 0;
    endtask

    task automatic do_reset(input int idx);
        n_rst   = 1'b0;
        command = 4'd0;
        bank    = 2'd0;
        @(posedge clk);
        #1;
        model_reset();
        check("reset", idx, got, {4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 3'd0});
        n_rst = 1'b1;
    endtask

    task automatic step(input logic [3:0] c, input logic [1:0] b);
        logic [2:0] code;
        command = c;
        bank    = b;
        code    = mcode(c, int'(b));
        if (code == 3'd0) begin
            if (c == 4'd1) begin
                mopen[b] = 1'b1;
                act_t[b] = now;
            end
            if (c == 4'd5 && bst(b, now) == 2) begin
                mopen[b] = 1'b0;
                pre_t[b] = now;
            end
            if (c == 4'd4)
                for (int i = 0; i < 4; i++)
                    if (bst(i, now) == 2) begin
                        mopen[i] = 1'b0;
                        pre_t[i] = now;
                    end
            if (c == 4'd6)
                ref_t = now;
        end
        @(posedge clk);
        #1;
        now++;
        mexp = mout(code);
    endtask

    typedef struct {
        logic [3:0]  c;
        logic [1:0]  b;
        logic [16:0] e;
    } vec_t;

    vec_t tab [33];

    function automatic vec_t v(logic [3:0] c, logic [1:0] b, logic [3:0] o, logic [3:0] r,
                               logic [3:0] id, logic a, logic [2:0] code);
        vec_t x;
        x.c = c;
        x.b = b;
        x.e = {o, r, id, a, code != 3'd0, code};
        return x;
    endfunction

    initial begin
        tab[0]  = v(0, 0, 4'h0, 4'h0, 4'hF, 1, 0);
        tab[1]  = v(0, 0, 4'h0, 4'h0, 4'hF, 1, 0);
        tab[2]  = v(0, 0, 4'h0, 4'h0, 4'hF, 1, 0);
        tab[3]  = v(1, 2, 4'h4, 4'h0, 4'hB, 0, 0);
        tab[4]  = v(0, 0, 4'h4, 4'h4, 4'hB, 0, 0);
        tab[5]  = v(2, 2, 4'h4, 4'h4, 4'hB, 0, 0);
        tab[6]  = v(1, 1, 4'h6, 4'h4, 4'h9, 0, 0);
        tab[7]  = v(2, 1, 4'h6, 4'h6, 4'h9, 0, 2);
        tab[8]  = v(5, 2, 4'h2, 4'h2, 4'h9, 0, 0);
        tab[9]  = v(0, 0, 4'h2, 4'h2, 4'hD, 0, 0);
        tab[10] = v(1, 1, 4'h2, 4'h2, 4'hD, 0, 1);
        tab[11] = v(6, 0, 4'h2, 4'h2, 4'hD, 0, 4);
        tab[12] = v(4, 0, 4'h0, 4'h0, 4'hD, 0, 0);
        tab[13] = v(0, 0, 4'h0, 4'h0, 4'hF, 1, 0);
        tab[14] = v(1, 0, 4'h1, 4'h0, 4'hE, 0, 0);
        tab[15] = v(5, 0, 4'h1, 4'h1, 4'hE, 0, 3);
        tab[16] = v(1, 3, 4'h9, 4'h1, 4'h6, 0, 0);
        tab[17] = v(4, 0, 4'h9, 4'h9, 4'h6, 0, 3);
        tab[18] = v(4, 0, 4'h0, 4'h0, 4'h6, 0, 0);
        tab[19] = v(0, 0, 4'h0, 4'h0, 4'hF, 1, 0);
        tab[20] = v(6, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        tab[21] = v(1, 0, 4'h0, 4'h0, 4'h0, 0, 5);
        tab[22] = v(0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        tab[23] = v(9, 0, 4'h0, 4'h0, 4'h0, 0, 5);
        tab[24] = v(0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        tab[25] = v(0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        tab[26] = v(0, 0, 4'h0, 4'h0, 4'hF, 1, 0);
        tab[27] = v(9, 0, 4'h0, 4'h0, 4'hF, 1, 6);
        tab[28] = v(15, 0, 4'h0, 4'h0, 4'hF, 1, 6);
        tab[29] = v(7, 0, 4'h0, 4'h0, 4'hF, 1, 0);
        tab[30] = v(3, 3, 4'h0, 4'h0, 4'hF, 1, 2);
        tab[31] = v(5, 3, 4'h0, 4'h0, 4'hF, 1, 0);
        tab[32] = v(0, 0, 4'h0, 4'h0, 4'hF, 1, 0);

        n_rst   = 1'b0;
        command = 4'd0;
        bank    = 2'd0;
        @(posedge clk);
        #1;
        do_reset(0);

        for (int k = 0; k < 33; k++) begin
            step(tab[k].c, tab[k].b);
            check("table", k, got, tab[k].e);
        end

        // Reset in the middle of a refresh and of an activation abandons both windows
        step(4'd6, 2'd0);
        step(4'd0, 2'd0);
        check("mid_ref", 0, got, mexp);
        do_reset(1);
        step(4'd0, 2'd0);
        check("post_rst", 0, got, {4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 3'd0});
        step(4'd1, 2'd1);
        do_reset(2);
        step(4'd1, 2'd1);
        check("post_rst", 1, got, {4'h2, 4'h0, 4'hD, 1'b0, 1'b0, 3'd0});
        step(4'd0, 2'd0);
        check("post_rst", 2, got, {4'h2, 4'h2, 4'hD, 1'b0, 1'b0, 3'd0});

        for (int k = 0; k < 3000; k++) begin
            logic [3:0] c;
            if ($urandom_range(0, 299) == 0) begin
                do_reset(100 + k);
            end else begin
                c = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(8, 15)) :
                    ($urandom_range(0, 2) == 0)  ? 4'd0 : 4'($urandom_range(0, 7));
                step(c, 2'($urandom_range(0, 3)));
                check("rand", k, got, mexp);
            end
        end

`ifdef SDRAM_TRACK_LOG_EN
        do_reset(3);
        step(4'd2, 2'd0);
        for (int k = 0; k < 299; k++)
            step(4'd9, 2'd1);
        step(4'd0, 2'd0);
        step(4'd0, 2'd0);
        check("viol_count", 0, 17'(viol_count), 17'd255);
        check("first_code", 0, 17'(first_code), 17'd2);
        do_reset(4);
        check("log_clear", 0, 17'({viol_count, first_code}), 17'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
